// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line I-cache,
// byte-serial miss refill over the memory-controller port, and IF/ID presentation.
module if_stage #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  stall_in,
    input  logic        jump_or_not,
    input  logic [31:0] jump_target,
    input  logic [7:0]  mem_data_in,
    input  logic        mem_valid_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] pc_out_to_if_id,
    output logic [31:0] inst_out_to_if_id,
    output logic        if_stall_req
);
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_out_n, inst_out_n, mem_addr_n;
    logic        mem_req_n, if_stall_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [23:0] fill_buf, fill_buf_n;
    logic [31:0] hold_word, hold_word_n;

    logic [31:0]      cache_data [LINES];
    logic [TAG_W-1:0] cache_tag  [LINES];
    logic [LINES-1:0] cache_valid;

    logic [ICACHE_IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic                    hit, stall_if, last_byte, cache_we;
    logic [31:0]             fill_word;
    logic                    unused_ok;

    assign pc_idx    = pc[ICACHE_IDX_W+1:2];
    assign pc_tag    = pc[31:ICACHE_IDX_W+2];
    assign hit       = cache_valid[pc_idx] && (cache_tag[pc_idx] == pc_tag);
    assign stall_if  = stall_in[0];
    assign last_byte = (state == FETCH) && mem_valid_in && (byte_cnt == 2'd3);
    assign fill_word = {mem_data_in, fill_buf};
    // An aborted (jump) or reset fetch never reaches the cache.
    assign cache_we  = last_byte && !jump_or_not && !rst;
    assign unused_ok = ^stall_in[4:1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (jump_or_not) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (!stall_if && !hit) state_n = FETCH;
                FETCH:   if (last_byte) state_n = stall_if ? HOLD : IDLE;
                HOLD:    if (!stall_if) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_n        = pc;
        pc_out_n    = pc_out_to_if_id;
        inst_out_n  = inst_out_to_if_id;
        mem_req_n   = mem_req_out;
        mem_addr_n  = mem_addr_out;
        if_stall_n  = if_stall_req;
        byte_cnt_n  = byte_cnt;
        fill_buf_n  = fill_buf;
        hold_word_n = hold_word;
        if (jump_or_not) begin
            pc_n       = jump_target & ~32'h3;
            pc_out_n   = '0;
            inst_out_n = '0;
            mem_req_n  = 1'b0;
            if_stall_n = 1'b0;
            byte_cnt_n = '0;
        end else begin
            case (state)
                IDLE: if (!stall_if) begin
                    if (hit) begin
                        pc_out_n   = pc;
                        inst_out_n = cache_data[pc_idx];
                        pc_n       = pc + 32'd4;
                    end else begin
                        pc_out_n   = '0;
                        inst_out_n = '0;
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc;
                        if_stall_n = 1'b1;
                        byte_cnt_n = '0;
                    end
                end
                FETCH: if (mem_valid_in) begin
                    mem_addr_n = mem_addr_out + 32'd1;
                    byte_cnt_n = byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0: fill_buf_n[7:0]   = mem_data_in;
                        2'd1: fill_buf_n[15:8]  = mem_data_in;
                        2'd2: fill_buf_n[23:16] = mem_data_in;
                        default: begin
                            mem_req_n  = 1'b0;
                            if_stall_n = 1'b0;
                            if (stall_if) begin
                                hold_word_n = fill_word;
                            end else begin
                                pc_out_n   = pc;
                                inst_out_n = fill_word;
                                pc_n       = pc + 32'd4;
                            end
                        end
                    endcase
                end
                HOLD: if (!stall_if) begin
                    pc_out_n   = pc;
                    inst_out_n = hold_word;
                    pc_n       = pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= RESET_PC;
            pc_out_to_if_id   <= '0;
            inst_out_to_if_id <= '0;
            mem_req_out       <= 1'b0;
            mem_addr_out      <= '0;
            if_stall_req      <= 1'b0;
            byte_cnt          <= '0;
        end else begin
            pc                <= pc_n;
            pc_out_to_if_id   <= pc_out_n;
            inst_out_to_if_id <= inst_out_n;
            mem_req_out       <= mem_req_n;
            mem_addr_out      <= mem_addr_n;
            if_stall_req      <= if_stall_n;
            byte_cnt          <= byte_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        fill_buf  <= fill_buf_n;
        hold_word <= hold_word_n;
    end

    // Only the valid bits carry reset; tags and data are qualified by them.
    always_ff @(posedge clk) begin
        if (rst)           cache_valid         <= '0;
        else if (cache_we) cache_valid[pc_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (cache_we) begin
            cache_data[pc_idx] <= fill_word;
            cache_tag[pc_idx]  <= pc_tag;
        end
    end
endmodule
